// File: rtl/sp_ram_arbiter_if.sv
// Bundle of the two master command/response channels and the single-port RAM pins
// shared by sp_ram_arbiter, its masters and the RAM.
interface sp_ram_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_rdata;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_rdata;

  logic             ram_ena;
  logic             ram_wea;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_ena, ram_wea, ram_addr, ram_din,
    input  ram_dout
  );

  // Requesting masters side
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata
  );

  // Single-port RAM side
  modport ram (
    input  ram_ena, ram_wea, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM with a 3-cycle read response.
// Define SP_RAM_ARB_RR_EN for round-robin contention; otherwise master 0 has fixed priority.
module sp_ram_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  sp_ram_arbiter_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } stage_e;

  logic             grant0_c;
  logic             grant1_c;

  logic             last_q,  last_d;
  logic             ena_q,   ena_d;
  logic             wea_q,   wea_d;
  logic [AW-1:0]    addr_q,  addr_d;
  logic [WIDTH-1:0] din_q,   din_d;

  stage_e           rd1_q,   rd1_d;
  logic             tag1_q,  tag1_d;
  stage_e           rd2_q,   rd2_d;
  logic             tag2_q,  tag2_d;

  logic             rsp0_v_q, rsp0_v_d;
  logic             rsp1_v_q, rsp1_v_d;
  logic [WIDTH-1:0] rsp0_d_q, rsp0_d_d;
  logic [WIDTH-1:0] rsp1_d_q, rsp1_d_d;

  // Grant selection; readys are held low throughout reset
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef SP_RAM_ARB_RR_EN
        grant0_c = last_q;
        grant1_c = !last_q;
`else
        grant0_c = 1'b1;
`endif
      end else begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  // Command stage, read-tag pipeline and response capture
  always_comb begin
    last_d   = last_q;
    ena_d    = 1'b0;
    wea_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    rd1_d    = ST_IDLE;
    tag1_d   = tag1_q;
    rd2_d    = rd1_q;
    tag2_d   = tag1_q;
    rsp0_v_d = 1'b0;
    rsp1_v_d = 1'b0;
    rsp0_d_d = rsp0_d_q;
    rsp1_d_d = rsp1_d_q;

    if (grant0_c) begin
      last_d = 1'b0;
      ena_d  = 1'b1;
      wea_d  = bus.req0_we;
      addr_d = bus.req0_addr;
      din_d  = bus.req0_wdata;
      if (!bus.req0_we) begin
        rd1_d  = ST_BUSY;
        tag1_d = 1'b0;
      end
    end else if (grant1_c) begin
      last_d = 1'b1;
      ena_d  = 1'b1;
      wea_d  = bus.req1_we;
      addr_d = bus.req1_addr;
      din_d  = bus.req1_wdata;
      if (!bus.req1_we) begin
        rd1_d  = ST_BUSY;
        tag1_d = 1'b1;
      end
    end

    // RAM output is valid while the second stage holds the read
    if (rd2_q == ST_BUSY) begin
      if (tag2_q) begin
        rsp1_v_d = 1'b1;
        rsp1_d_d = bus.ram_dout;
      end else begin
        rsp0_v_d = 1'b1;
        rsp0_d_d = bus.ram_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd1_q    <= ST_IDLE;
      tag1_q   <= 1'b0;
      rd2_q    <= ST_IDLE;
      tag2_q   <= 1'b0;
      rsp0_v_q <= 1'b0;
      rsp1_v_q <= 1'b0;
      rsp0_d_q <= '0;
      rsp1_d_q <= '0;
    end else begin
      last_q   <= last_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd1_q    <= rd1_d;
      tag1_q   <= tag1_d;
      rd2_q    <= rd2_d;
      tag2_q   <= tag2_d;
      rsp0_v_q <= rsp0_v_d;
      rsp1_v_q <= rsp1_v_d;
      rsp0_d_q <= rsp0_d_d;
      rsp1_d_q <= rsp1_d_d;
    end
  end

  assign bus.ram_ena    = ena_q;
  assign bus.ram_wea    = wea_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.rsp0_valid = rsp0_v_q;
  assign bus.rsp0_rdata = rsp0_d_q;
  assign bus.rsp1_valid = rsp1_v_q;
  assign bus.rsp1_rdata = rsp1_d_q;

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester arbiter that shares one single-port RAM (WIDTH x DEPTH, registered read, 1-cycle read latency) between two independent masters. Each master issues read/write commands over a valid/ready handshake. The arbiter grants at most one command per cycle, drives the RAM's enable/write/address/data pins from a registered command stage, and returns read data to the issuing master with a fixed latency. It sits directly in front of the team's single-port RAM, connected to that RAM's din/addr/wea/ena/dout pins.

## Interface
Parameters:
- WIDTH, 8, data width in bits
- DEPTH, 8, RAM words; address width AW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  master 0 command valid
- req0_ready  out  1  master 0 command accepted this cycle (combinational)
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  AW  command address
- req0_wdata  in  WIDTH  write data
- rsp0_valid  out  1  read data valid for master 0 (one-cycle pulse)
- rsp0_rdata  out  WIDTH  read data for master 0
- req1_*, rsp1_*  same set for master 1
- ram_ena  out  1  to RAM ena
- ram_wea  out  1  to RAM wea
- ram_addr  out  AW  to RAM addr
- ram_din  out  WIDTH  to RAM din
- ram_dout  in  WIDTH  from RAM dout

## Operation
- Grant is a combinational function of req0_valid, req1_valid and the last-served pointer `last`.
- req0_ready and req1_ready are never both 1.
- A command is accepted in cycle N when reqX_valid and reqX_ready are both 1. Accepted commands are never dropped.
- Only one valid requester: it is granted.
- Both requesters valid: arbitration is set by the macro (see Configuration).
- `last` updates on every accepted command to the index of the accepted master.
- Command stage: registers ena=1, we, addr, wdata and tag (master index) into ram_* in cycle N+1. With no acceptance, ram_ena=0 and ram_wea=0 in N+1, and ram_addr/ram_din hold their previous values.
- Read pipeline: a read tag/valid bit follows the command.
  - The RAM samples at the end of N+1, so ram_dout is valid in N+2.
  - The arbiter registers ram_dout into rspX_rdata and pulses rspX_valid=1 in N+3.
- Writes produce no response.
- Responses have no backpressure; masters must consume them.
- rspX_rdata holds its last value when rspX_valid=0.
- States per pipeline stage: IDLE (valid=0) and BUSY (valid=1, tag). There is no stall, so stages advance every cycle.

## Timing
- Reset values: req0_ready=req1_ready=0 while rst=1. ram_ena=ram_wea=0, ram_addr=0, ram_din=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
- `last` resets to 1, so master 0 wins the first contention.
- Read latency: accept in N -> rsp in N+3.
- Throughput: 1 command per cycle, aggregate across both masters.
- Back-to-back access to the same address: a write accepted in N followed by a read accepted in N+1 returns the new data.
- Reset asserted mid-operation: all in-flight reads are discarded and no rsp pulse occurs. Pipeline, `last` and outputs return to reset values immediately (asynchronous).
- Address is used as-is. DEPTH non-power-of-2 with an out-of-range address is a master error and is not checked.

## Configuration
- SP_RAM_ARB_RR_EN defined: round-robin. On contention, grant the master != `last`; alternating 0,1,0,1 under continuous dual requests.
- Not defined: fixed priority. Master 0 always wins contention; `last` is still kept but unused. Master 1 can starve.

## Test plan
- Reset, then master 0 writes addr 3 = 0xA5 (N), then reads addr 3 (N+1) -> ram_ena/ram_wea=1/1 in N+1; rsp0_valid=1, rsp0_rdata=0xA5 in N+4.
- Both masters valid reading addr 0..3 continuously with SP_RAM_ARB_RR_EN -> readys alternate 0,1,0,1 starting with master 0; each rsp tagged to the correct master 3 cycles after its accept.
- Same stimulus without SP_RAM_ARB_RR_EN -> req1_ready stays 0 until req0_valid drops; then master 1 is accepted the same cycle.
- Master 1 writes addr 5 = 0x3C while master 0 reads addr 5 in the next accepted slot -> rsp0_rdata=0x3C.
- Master 0 read accepted, rst pulsed in N+1 -> no rsp0_valid pulse; all outputs 0 during reset.
- No requests for 10 cycles -> ram_ena=0, no rsp pulses, readys 0.
